// File: rtl/wb_commit_pkg.sv
// ---------------------------------------------------------------------------
// wb_commit_pkg
// Shared definitions for the writeback/commit slice:
//   rf_wsel_e : writeback data select encodings (RF_WSEL_*)
//   WB_CW     : default scoreboard counter width
//   X0_IDX    : index of the hard-wired zero register
// ---------------------------------------------------------------------------
package wb_commit_pkg;

    typedef enum logic [1:0] {
        RF_WSEL_ALU = 2'd0,
        RF_WSEL_PC4 = 2'd1,
        RF_WSEL_EXT = 2'd2,
        RF_WSEL_RDO = 2'd3
    } rf_wsel_e;

    localparam int WB_CW  = 3;
    localparam int X0_IDX = 0;

endpackage

// File: rtl/wb_commit_if.sv
// ---------------------------------------------------------------------------
// wb_commit_if
// Bundles every signal between the commit stage and its neighbours:
//   MEM side    : in_valid/in_ready handshake, in_wsel, in_we, in_wr and the
//                 four writeback candidates, plus the wb_hold freeze
//   decode side : iss_* issue request/ready, q_r1/q_r2 read addresses,
//                 hz1/hz2 stall flags, byp1/byp2 + byp_data bypass
//   RF side     : rf_we, rf_wR, rf_wD write port
// modport master = the surrounding pipeline, modport slave = wb_commit.
// ---------------------------------------------------------------------------
interface wb_commit_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_wsel;
    logic            in_we;
    logic [AW-1:0]   in_wr;
    logic [XLEN-1:0] in_alu_c;
    logic [XLEN-1:0] in_pc4;
    logic [XLEN-1:0] in_ext;
    logic [XLEN-1:0] in_rdo;
    logic            wb_hold;
    logic            iss_valid;
    logic            iss_we;
    logic [AW-1:0]   iss_wr;
    logic            iss_ready;
    logic [AW-1:0]   q_r1;
    logic [AW-1:0]   q_r2;
    logic            hz1;
    logic            hz2;
    logic            byp1;
    logic            byp2;
    logic [XLEN-1:0] byp_data;
    logic            rf_we;
    logic [AW-1:0]   rf_wR;
    logic [XLEN-1:0] rf_wD;

    modport master (
        output in_valid, in_wsel, in_we, in_wr, in_alu_c, in_pc4, in_ext, in_rdo,
        output wb_hold, iss_valid, iss_we, iss_wr, q_r1, q_r2,
        input  in_ready, iss_ready, hz1, hz2, byp1, byp2, byp_data,
        input  rf_we, rf_wR, rf_wD
    );

    modport slave (
        input  in_valid, in_wsel, in_we, in_wr, in_alu_c, in_pc4, in_ext, in_rdo,
        input  wb_hold, iss_valid, iss_we, iss_wr, q_r1, q_r2,
        output in_ready, iss_ready, hz1, hz2, byp1, byp2, byp_data,
        output rf_we, rf_wR, rf_wD
    );
endinterface

// File: rtl/wb_commit_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_commit_scoreboard
// Per-register pending-write counters. Issue increments, commit decrements,
// both on the same register in one cycle cancel. Produces the issue-ready
// flag and the two read-port hazard flags.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   issue_req, iss_wr    decode wants to issue a writer of iss_wr
//   iss_ready            counter of iss_wr has room
//   commit_en, commit_wr RF write happening this cycle
//   q_r1/q_r2, byp1/byp2 read addresses and their bypass status
//   hz1/hz2              read must stall
// ---------------------------------------------------------------------------
module wb_commit_scoreboard
    import wb_commit_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = WB_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_req,
    input  logic [AW-1:0] iss_wr,
    output logic          iss_ready,
    input  logic          commit_en,
    input  logic [AW-1:0] commit_wr,
    input  logic [AW-1:0] q_r1,
    input  logic [AW-1:0] q_r2,
    input  logic          byp1,
    input  logic          byp2,
    output logic          hz1,
    output logic          hz2
);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0] X0      = AW'(X0_IDX);

    logic [CW-1:0]   cnt [NREG];
    logic            issue_en;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic [CW-1:0]   cnt_q1;
    logic [CW-1:0]   cnt_q2;

    assign iss_ready = (cnt[iss_wr] != CNT_MAX);
    assign issue_en  = issue_req & (iss_wr != X0) & iss_ready;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            inc_vec[i] = issue_en  && (iss_wr    == AW'(i));
            dec_vec[i] = commit_en && (commit_wr == AW'(i));
        end
    end

    // A commit against an empty counter saturates at zero rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt[i] <= cnt[i] + CW'(1);
                else if (dec_vec[i] && !inc_vec[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end

    // One pending writer can be covered by the bypass only if it is the one
    // committing right now; two or more always stall.
    assign cnt_q1 = cnt[q_r1];
    assign cnt_q2 = cnt[q_r2];
    assign hz1 = (q_r1 != X0) & ((cnt_q1 > CW'(1)) | ((cnt_q1 == CW'(1)) & !byp1));
    assign hz2 = (q_r2 != X0) & ((cnt_q2 > CW'(1)) | ((cnt_q2 == CW'(1)) & !byp2));

`ifndef SYNTHESIS
    commit_without_pending: assert property (
        @(posedge clk) disable iff (!rst_n) commit_en |-> (cnt[commit_wr] != '0)
    );
`endif

endmodule

// File: rtl/wb_commit.sv
// ---------------------------------------------------------------------------
// wb_commit
// Writeback/commit stage. Accepts completed instructions from MEM into a
// single WB register, selects the write data, drives the RF write port and
// reports hazard/bypass status for decode's two read addresses.
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  synchronous active-low reset
//   bus    wb_commit_if.slave: MEM handshake, decode issue/query, RF write
// ---------------------------------------------------------------------------
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = WB_CW
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_commit_if.slave  bus
);
    localparam logic [AW-1:0] X0 = AW'(X0_IDX);

    logic            accept;
    logic            vld_p1;
    rf_wsel_e        wsel_p1;
    logic            we_p1;
    logic [AW-1:0]   wr_p1;
    logic [XLEN-1:0] alu_c_p1;
    logic [XLEN-1:0] pc4_p1;
    logic [XLEN-1:0] ext_p1;
    logic [XLEN-1:0] rdo_p1;
    logic            rf_we;
    logic [XLEN-1:0] wdata;
    logic            byp1;
    logic            byp2;
    logic            sb_iss_ready;
    logic            sb_hz1;
    logic            sb_hz2;

    assign accept = bus.in_valid & !bus.wb_hold;

    // ---- MEM -> WB register boundary ----
    // wb_hold freezes the whole entry; otherwise the valid bit follows accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            wsel_p1  <= RF_WSEL_ALU;
            we_p1    <= 1'b0;
            wr_p1    <= '0;
            alu_c_p1 <= '0;
            pc4_p1   <= '0;
            ext_p1   <= '0;
            rdo_p1   <= '0;
        end else if (!bus.wb_hold) begin
            vld_p1 <= accept;
            if (accept) begin
                wsel_p1  <= rf_wsel_e'(bus.in_wsel);
                we_p1    <= bus.in_we;
                wr_p1    <= bus.in_wr;
                alu_c_p1 <= bus.in_alu_c;
                pc4_p1   <= bus.in_pc4;
                ext_p1   <= bus.in_ext;
                rdo_p1   <= bus.in_rdo;
            end
        end
    end

    // ---- WB register -> RF write port ----
    always_comb begin
        unique case (wsel_p1)
            RF_WSEL_ALU: wdata = alu_c_p1;
            RF_WSEL_PC4: wdata = pc4_p1;
            RF_WSEL_EXT: wdata = ext_p1;
            RF_WSEL_RDO: wdata = rdo_p1;
            default:     wdata = alu_c_p1;
        endcase
    end

    // rf_we already excludes x0, so the bypass compare needs no x0 guard.
    assign rf_we = vld_p1 & we_p1 & (wr_p1 != X0) & !bus.wb_hold;
    assign byp1  = rf_we & (wr_p1 == bus.q_r1);
    assign byp2  = rf_we & (wr_p1 == bus.q_r2);

    wb_commit_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .CW   (CW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue_req (bus.iss_valid & bus.iss_we),
        .iss_wr    (bus.iss_wr),
        .iss_ready (sb_iss_ready),
        .commit_en (rf_we),
        .commit_wr (wr_p1),
        .q_r1      (bus.q_r1),
        .q_r2      (bus.q_r2),
        .byp1      (byp1),
        .byp2      (byp2),
        .hz1       (sb_hz1),
        .hz2       (sb_hz2)
    );

    assign bus.in_ready  = !bus.wb_hold;
    assign bus.iss_ready = sb_iss_ready;
    assign bus.hz1       = sb_hz1;
    assign bus.hz2       = sb_hz2;
    assign bus.byp1      = byp1;
    assign bus.byp2      = byp2;
    assign bus.byp_data  = wdata;
    assign bus.rf_we     = rf_we;
    assign bus.rf_wR     = wr_p1;
    assign bus.rf_wD     = wdata;

endmodule

// File: tb/tb_wb_commit.sv
// ---------------------------------------------------------------------------
// tb_wb_commit
// Self-checking bench for wb_commit: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the pending
// write counts and the single WB entry.
// ---------------------------------------------------------------------------
module tb_wb_commit;
    import wb_commit_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CMAX = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_commit_if #(.XLEN(XLEN), .AW(AW)) bus ();

    wb_commit #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .CW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: outstanding writers per register and the WB entry
    // (data selected at accept time).
    int              cnt_m [NREG];
    bit              m_v;
    bit              m_we;
    logic [AW-1:0]   m_wr;
    logic [XLEN-1:0] m_data;

    bit e_in_ready, e_iss_ready, e_rf_we, e_byp1, e_byp2, e_hz1, e_hz2;

    task automatic model_outputs();
        e_in_ready  = !bus.wb_hold;
        e_iss_ready = cnt_m[bus.iss_wr] < CMAX;
        e_rf_we     = m_v && m_we && (m_wr != 0) && !bus.wb_hold;
        e_byp1      = e_rf_we && (bus.q_r1 == m_wr);
        e_byp2      = e_rf_we && (bus.q_r2 == m_wr);
        e_hz1 = (bus.q_r1 != 0) && (cnt_m[bus.q_r1] > 1 || (cnt_m[bus.q_r1] == 1 && !e_byp1));
        e_hz2 = (bus.q_r2 != 0) && (cnt_m[bus.q_r2] > 1 || (cnt_m[bus.q_r2] == 1 && !e_byp2));
    endtask

    // Advance the model with the inputs present now, then step one clock.
    task automatic tick();
        bit issue;
        model_outputs();
        issue = bus.iss_valid && bus.iss_we && (bus.iss_wr != 0) && e_iss_ready;
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt_m[i] = 0;
            m_v = 0; m_we = 0; m_wr = '0; m_data = '0;
        end else begin
            if (e_rf_we && cnt_m[m_wr] > 0) cnt_m[m_wr]--;
            if (issue) cnt_m[bus.iss_wr]++;
            if (!bus.wb_hold) begin
                m_v = bus.in_valid;
                if (bus.in_valid) begin
                    m_we = bus.in_we;
                    m_wr = bus.in_wr;
                    case (bus.in_wsel)
                        2'd0:    m_data = bus.in_alu_c;
                        2'd1:    m_data = bus.in_pc4;
                        2'd2:    m_data = bus.in_ext;
                        default: m_data = bus.in_rdo;
                    endcase
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.in_valid  = 0; bus.in_we = 0; bus.in_wr = '0; bus.in_wsel = 2'd0;
        bus.in_alu_c  = $urandom; bus.in_pc4 = $urandom;
        bus.in_ext    = $urandom; bus.in_rdo = $urandom;
        bus.wb_hold   = 0;
        bus.iss_valid = 0; bus.iss_we = 0; bus.iss_wr = '0;
        bus.q_r1      = '0; bus.q_r2 = '0;
    endtask

    task automatic offer(input logic [AW-1:0] wr, input logic [1:0] wsel);
        bus.in_valid = 1; bus.in_we = 1; bus.in_wr = wr; bus.in_wsel = wsel;
    endtask

    task automatic issue(input logic [AW-1:0] wr);
        bus.iss_valid = 1; bus.iss_we = 1; bus.iss_wr = wr;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        for (int c = 0; c < 5; c++) begin
            drive_idle();
            bus.q_r1 = AW'($urandom_range(0, 31));
            bus.q_r2 = AW'($urandom_range(0, 31));
            bus.iss_wr = AW'($urandom_range(0, 31));
            #1;
            checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we c%0d got %0b want 0", c, bus.rf_we); end
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready c%0d got %0b want 1", c, bus.in_ready); end
            checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready c%0d got %0b want 1", c, bus.iss_ready); end
            checks++; if ({bus.hz1, bus.hz2} !== 2'b00) begin errors++; $display("FAIL reset_hz c%0d got %b want 00", c, {bus.hz1, bus.hz2}); end
            checks++; if ({bus.byp1, bus.byp2} !== 2'b00) begin errors++; $display("FAIL reset_byp c%0d got %b want 00", c, {bus.byp1, bus.byp2}); end
            if (c == 0) begin
                checks++; if (bus.rf_wR !== '0) begin errors++; $display("FAIL reset_rf_wR got %0d want 0", bus.rf_wR); end
                checks++; if (bus.rf_wD !== '0) begin errors++; $display("FAIL reset_rf_wD got %h want 0", bus.rf_wD); end
            end
            tick();
        end
    endtask

    task automatic test_single_write();
        drive_idle(); issue(5); #1;
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL single_iss_ready got %0b want 1", bus.iss_ready); end
        tick();
        drive_idle(); offer(5, RF_WSEL_ALU); bus.in_alu_c = 32'h1234; bus.q_r1 = 5; #1;
        checks++; if (bus.hz1 !== 1'b1) begin errors++; $display("FAIL single_hz_pending got %0b want 1", bus.hz1); end
        tick();
        drive_idle(); bus.q_r1 = 5; #1;
        checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL single_rf_we got %0b want 1", bus.rf_we); end
        checks++; if (bus.rf_wR !== 5'd5) begin errors++; $display("FAIL single_rf_wR got %0d want 5", bus.rf_wR); end
        checks++; if (bus.rf_wD !== 32'h1234) begin errors++; $display("FAIL single_rf_wD got %h want 00001234", bus.rf_wD); end
        checks++; if (bus.byp_data !== 32'h1234) begin errors++; $display("FAIL single_byp_data got %h want 00001234", bus.byp_data); end
        checks++; if ({bus.byp1, bus.hz1} !== 2'b10) begin errors++; $display("FAIL single_byp_hz got %b want 10", {bus.byp1, bus.hz1}); end
        tick();
        drive_idle(); bus.q_r1 = 5; #1;
        checks++; if ({bus.rf_we, bus.byp1, bus.hz1} !== 3'b000) begin errors++; $display("FAIL single_after got %b want 000", {bus.rf_we, bus.byp1, bus.hz1}); end
        tick();
    endtask

    task automatic test_multi_pending();
        logic [XLEN-1:0] p, e;
        p = $urandom; e = $urandom;
        drive_idle(); issue(7); tick();
        drive_idle(); issue(7); tick();
        drive_idle(); offer(7, RF_WSEL_PC4); bus.in_pc4 = p; bus.q_r2 = 7; #1;
        checks++; if ({bus.hz2, bus.byp2} !== 2'b10) begin errors++; $display("FAIL multi_two_pending got %b want 10", {bus.hz2, bus.byp2}); end
        tick();
        drive_idle(); offer(7, RF_WSEL_EXT); bus.in_ext = e; bus.q_r2 = 7; #1;
        checks++; if ({bus.rf_we, bus.byp2, bus.hz2} !== 3'b111) begin errors++; $display("FAIL multi_first_commit got %b want 111", {bus.rf_we, bus.byp2, bus.hz2}); end
        checks++; if (bus.rf_wD !== p) begin errors++; $display("FAIL multi_pc4_data got %h want %h", bus.rf_wD, p); end
        tick();
        drive_idle(); bus.q_r2 = 7; #1;
        checks++; if ({bus.rf_we, bus.byp2, bus.hz2} !== 3'b110) begin errors++; $display("FAIL multi_second_commit got %b want 110", {bus.rf_we, bus.byp2, bus.hz2}); end
        checks++; if (bus.rf_wD !== e) begin errors++; $display("FAIL multi_ext_data got %h want %h", bus.rf_wD, e); end
        tick();
        drive_idle(); bus.q_r2 = 7; #1;
        checks++; if ({bus.rf_we, bus.hz2} !== 2'b00) begin errors++; $display("FAIL multi_drained got %b want 00", {bus.rf_we, bus.hz2}); end
        tick();
    endtask

    task automatic test_x0();
        drive_idle(); offer(0, RF_WSEL_RDO); issue(0); #1;
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready got %0b want 1", bus.iss_ready); end
        tick();
        drive_idle(); #1;
        checks++; if ({bus.rf_we, bus.hz1, bus.byp1, bus.byp2} !== 4'b0000) begin errors++; $display("FAIL x0_no_write got %b want 0000", {bus.rf_we, bus.hz1, bus.byp1, bus.byp2}); end
        for (int r = 1; r < NREG; r++) begin
            bus.q_r1 = AW'(r); bus.q_r2 = AW'(NREG - r); #1;
            checks++; if ({bus.hz1, bus.hz2} !== 2'b00) begin errors++; $display("FAIL x0_sb_clean r%0d got %b want 00", r, {bus.hz1, bus.hz2}); end
        end
        tick();
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 6; k++) begin
            drive_idle(); issue(3); #1;
            checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL sat_fill k%0d got %0b want 1", k, bus.iss_ready); end
            tick();
        end
        drive_idle(); offer(3, RF_WSEL_ALU); tick();
        // issue and commit on x3 together: count must stay at 6
        drive_idle(); issue(3); #1;
        checks++; if ({bus.rf_we, bus.iss_ready} !== 2'b11) begin errors++; $display("FAIL sat_issue_commit got %b want 11", {bus.rf_we, bus.iss_ready}); end
        tick();
        drive_idle(); issue(3); #1;
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL sat_at_six got %0b want 1", bus.iss_ready); end
        tick();
        drive_idle(); issue(3); #1;
        checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL sat_full got %0b want 0", bus.iss_ready); end
        tick();
        drive_idle(); bus.iss_wr = 3; bus.q_r1 = 3; #1;
        checks++; if ({bus.iss_ready, bus.hz1} !== 2'b01) begin errors++; $display("FAIL sat_still_full got %b want 01", {bus.iss_ready, bus.hz1}); end
        tick();
    endtask

    task automatic test_hold_reset();
        logic [XLEN-1:0] b;
        b = $urandom;
        drive_idle(); offer(3, RF_WSEL_PC4); bus.in_pc4 = b; tick();
        for (int h = 0; h < 2; h++) begin
            drive_idle(); bus.wb_hold = 1; offer(9, RF_WSEL_ALU); #1;
            checks++; if ({bus.rf_we, bus.in_ready} !== 2'b00) begin errors++; $display("FAIL hold_frozen h%0d got %b want 00", h, {bus.rf_we, bus.in_ready}); end
            tick();
        end
        drive_idle(); bus.iss_wr = 3; #1;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wR !== 5'd3 || bus.rf_wD !== b) begin errors++; $display("FAIL hold_release got we=%0b wr=%0d wd=%h want we=1 wr=3 wd=%h", bus.rf_we, bus.rf_wR, bus.rf_wD, b); end
        checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL hold_cnt_full got %0b want 0", bus.iss_ready); end
        tick();
        drive_idle(); offer(3, RF_WSEL_EXT); bus.iss_wr = 3; #1;
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL hold_cnt_six got %0b want 1", bus.iss_ready); end
        tick();
        drive_idle(); bus.wb_hold = 1; rst_n = 0; tick();
        rst_n = 1; drive_idle(); bus.iss_wr = 3; #1;
        checks++; if ({bus.rf_we, bus.iss_ready} !== 2'b01) begin errors++; $display("FAIL rst_mid_entry got %b want 01", {bus.rf_we, bus.iss_ready}); end
        checks++; if (bus.rf_wR !== '0 || bus.rf_wD !== '0) begin errors++; $display("FAIL rst_mid_fields got wr=%0d wd=%h want 0 0", bus.rf_wR, bus.rf_wD); end
        for (int r = 1; r < NREG; r++) begin
            bus.q_r1 = AW'(r); bus.q_r2 = AW'(r); #1;
            checks++; if ({bus.hz1, bus.hz2} !== 2'b00) begin errors++; $display("FAIL rst_mid_cnt r%0d got %b want 00", r, {bus.hz1, bus.hz2}); end
        end
        tick();
    endtask

    task automatic test_random();
        int avail;
        logic [AW-1:0] r;
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            bus.wb_hold = ($urandom_range(0, 7) == 0);
            bus.in_valid = $urandom_range(0, 1);
            bus.in_wsel = 2'($urandom_range(0, 3));
            // only commit writers that were issued and are not already in WB
            r = AW'($urandom_range(1, 7));
            avail = cnt_m[r] - ((m_v && m_we && m_wr == r) ? 1 : 0);
            if (avail > 0) begin bus.in_we = 1; bus.in_wr = r; end
            else if ($urandom_range(0, 1) == 1) begin bus.in_we = 1; bus.in_wr = '0; end
            else begin bus.in_we = 0; bus.in_wr = AW'($urandom_range(0, 31)); end
            bus.iss_valid = $urandom_range(0, 1);
            bus.iss_we = ($urandom_range(0, 3) != 0);
            bus.iss_wr = AW'($urandom_range(0, 7));
            bus.q_r1 = ($urandom_range(0, 1) == 1) ? m_wr : AW'($urandom_range(0, 7));
            bus.q_r2 = ($urandom_range(0, 1) == 1) ? m_wr : AW'($urandom_range(0, 7));
            #1;
            model_outputs();
            checks++; if (bus.in_ready !== e_in_ready) begin errors++; $display("FAIL rnd_in_ready c%0d got %0b want %0b", c, bus.in_ready, e_in_ready); end
            checks++; if (bus.iss_ready !== e_iss_ready) begin errors++; $display("FAIL rnd_iss_ready c%0d got %0b want %0b", c, bus.iss_ready, e_iss_ready); end
            checks++; if (bus.rf_we !== e_rf_we) begin errors++; $display("FAIL rnd_rf_we c%0d got %0b want %0b", c, bus.rf_we, e_rf_we); end
            checks++; if ({bus.byp1, bus.byp2} !== {e_byp1, e_byp2}) begin errors++; $display("FAIL rnd_byp c%0d got %b want %b", c, {bus.byp1, bus.byp2}, {e_byp1, e_byp2}); end
            checks++; if ({bus.hz1, bus.hz2} !== {e_hz1, e_hz2}) begin errors++; $display("FAIL rnd_hz c%0d got %b want %b", c, {bus.hz1, bus.hz2}, {e_hz1, e_hz2}); end
            if (e_rf_we) begin
                checks++; if (bus.rf_wR !== m_wr || bus.rf_wD !== m_data || bus.byp_data !== m_data) begin
                    errors++; $display("FAIL rnd_wdata c%0d got wr=%0d wd=%h bd=%h want wr=%0d wd=%h", c, bus.rf_wR, bus.rf_wD, bus.byp_data, m_wr, m_data);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) cnt_m[i] = 0;
        m_v = 0; m_we = 0; m_wr = '0; m_data = '0;
        test_reset();
        test_single_write();
        test_multi_pending();
        test_x0();
        test_saturate();
        test_hold_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
